// File: rtl/vx_dot8_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vx_dot8_dispatch_pkg
//  Description : Shared widths and packet-count / PID-width helpers for the
//                dot8 warp dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
package vx_dot8_dispatch_pkg;

  localparam int NUM_THREADS   = 4;
  localparam int XLEN          = 32;
  localparam int UUID_WIDTH    = 44;
  localparam int NW_WIDTH      = 2;
  localparam int PC_WIDTH      = 32;
  localparam int NUM_REGS_BITS = 5;
  localparam int OP_TYPE_BITS  = 4;
  localparam int OP_ARGS_BITS  = 8;

  // Number of packets a warp is split into for a given lane count.
  function automatic int calc_num_packets(input int num_lanes);
    return NUM_THREADS / num_lanes;
  endfunction

  // PID field width; never zero so a single-packet build still has a pid bit.
  function automatic int calc_pid_width(input int num_packets);
    return (num_packets > 1) ? $clog2(num_packets) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_dot8_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : vx_dispatch_if / vx_execute_if
//  Description : Full-warp dispatch bus and lane-sliced execute bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vx_dispatch_if;
  import vx_dot8_dispatch_pkg::*;

  logic                                 valid;
  logic                                 ready;
  logic [UUID_WIDTH-1:0]                uuid;
  logic [NW_WIDTH-1:0]                  wid;
  logic [NUM_THREADS-1:0]               tmask;
  logic [PC_WIDTH-1:0]                  PC;
  logic                                 wb;
  logic [NUM_REGS_BITS-1:0]             rd;
  logic [NUM_THREADS-1:0][XLEN-1:0]     rs1_data;
  logic [NUM_THREADS-1:0][XLEN-1:0]     rs2_data;

  modport master (output valid, uuid, wid, tmask, PC, wb, rd, rs1_data, rs2_data,
                  input  ready);
  modport slave  (input  valid, uuid, wid, tmask, PC, wb, rd, rs1_data, rs2_data,
                  output ready);
endinterface

interface vx_execute_if #(
  parameter int NUM_LANES = 1,
  parameter int PID_WIDTH = 1
);
  import vx_dot8_dispatch_pkg::*;

  logic                                 valid;
  logic                                 ready;
  logic [UUID_WIDTH-1:0]                uuid;
  logic [NW_WIDTH-1:0]                  wid;
  logic [NUM_LANES-1:0]                 tmask;
  logic [PC_WIDTH-1:0]                  PC;
  logic                                 wb;
  logic [NUM_REGS_BITS-1:0]             rd;
  logic [OP_TYPE_BITS-1:0]              op_type;
  logic [OP_ARGS_BITS-1:0]              op_args;
  logic [NUM_LANES-1:0][XLEN-1:0]       rs1_data;
  logic [NUM_LANES-1:0][XLEN-1:0]       rs2_data;
  logic [NUM_LANES-1:0][XLEN-1:0]       rs3_data;
  logic [PID_WIDTH-1:0]                 pid;
  logic                                 sop;
  logic                                 eop;

  modport master (output valid, uuid, wid, tmask, PC, wb, rd, op_type, op_args,
                         rs1_data, rs2_data, rs3_data, pid, sop, eop,
                  input  ready);
  modport slave  (input  valid, uuid, wid, tmask, PC, wb, rd, op_type, op_args,
                         rs1_data, rs2_data, rs3_data, pid, sop, eop,
                  output ready);
endinterface
`default_nettype wire

// File: rtl/vx_dot8_dispatch_pkt_select.sv
`default_nettype none
// ============================================================================
//  Module      : vx_dot8_dispatch_pkt_select
//  Description : Finds non-empty lane slices of a thread mask: first non-empty
//                packet, next non-empty packet after a given pid, and whether
//                the given pid is the last non-empty one. An all-zero mask
//                reports pid 0 as both first and last.
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_dot8_dispatch_pkt_select
  import vx_dot8_dispatch_pkg::*;
#(
  parameter int NUM_LANES   = 1,
  parameter int NUM_PACKETS = 4,
  parameter int PID_WIDTH   = 2
) (
  input  wire logic [NUM_THREADS-1:0] tmask_i,
  input  wire logic [PID_WIDTH-1:0]   pid_i,
  output logic      [PID_WIDTH-1:0]   next_pid_o,
  output logic      [PID_WIDTH-1:0]   first_pid_o,
  output logic                        last_o
);

  logic [NUM_PACKETS-1:0] w_nonempty;

  for (genvar p = 0; p < NUM_PACKETS; p++) begin : g_nonempty
    assign w_nonempty[p] = |tmask_i[p*NUM_LANES +: NUM_LANES];
  end

  // Priority scan for the lowest non-empty packet overall and above pid_i.
  always_comb begin
    logic found_first;
    logic found_next;
    first_pid_o = '0;
    next_pid_o  = pid_i;
    last_o      = 1'b1;
    found_first = 1'b0;
    found_next  = 1'b0;
    for (int p = 0; p < NUM_PACKETS; p++) begin
      if (w_nonempty[p] && !found_first) begin
        first_pid_o = PID_WIDTH'(p);
        found_first = 1'b1;
      end
      if (w_nonempty[p] && (p > int'(pid_i)) && !found_next) begin
        next_pid_o = PID_WIDTH'(p);
        found_next = 1'b1;
        last_o     = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vx_dot8_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : vx_dot8_dispatch
//  Description : Captures a full warp and issues it to the dot8 unit as
//                NUM_LANES-wide packets with pid/sop/eop framing. A new warp
//                may be accepted in the eop handshake cycle (no bubble).
//                Optional macro DOT8_SKIP_EMPTY_EN: packets whose tmask slice
//                is all-zero are not issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_dot8_dispatch
  import vx_dot8_dispatch_pkg::*;
#(
  parameter string INSTANCE_ID = "",
  parameter int    NUM_LANES   = 1
) (
  input  wire logic     clk,
  input  wire logic     reset,
  vx_dispatch_if.slave  dispatch_if,
  vx_execute_if.master  execute_if
);

  localparam int NUM_PACKETS = calc_num_packets(NUM_LANES);
  localparam int PID_WIDTH   = calc_pid_width(NUM_PACKETS);

  if (NUM_PACKETS * NUM_LANES != NUM_THREADS) begin : g_lane_check
    $error("%s: NUM_LANES must divide NUM_THREADS", INSTANCE_ID);
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                            state_q, state_d;
  logic [PID_WIDTH-1:0]              pid_q, pid_d;
  logic                              sop_q, sop_d;

  logic [UUID_WIDTH-1:0]             uuid_q;
  logic [NW_WIDTH-1:0]               wid_q;
  logic [NUM_THREADS-1:0]            tmask_q;
  logic [PC_WIDTH-1:0]               pc_q;
  logic                              wb_q;
  logic [NUM_REGS_BITS-1:0]          rd_q;
  logic [NUM_THREADS-1:0][XLEN-1:0]  rs1_q;
  logic [NUM_THREADS-1:0][XLEN-1:0]  rs2_q;

  logic                              w_valid;
  logic                              w_disp_ready;
  logic                              w_disp_fire;
  logic                              w_exe_fire;
  logic                              w_last;
  logic [PID_WIDTH-1:0]              w_first_pid;
  logic [PID_WIDTH-1:0]              w_next_pid;

`ifdef DOT8_SKIP_EMPTY_EN
  logic [PID_WIDTH-1:0] w_unused_cur_first;
  logic [PID_WIDTH-1:0] w_unused_in_next;
  logic                 w_unused_in_last;

  // Walk the captured mask: next pid to issue and whether the current is last.
  vx_dot8_dispatch_pkt_select #(
    .NUM_LANES   (NUM_LANES),
    .NUM_PACKETS (NUM_PACKETS),
    .PID_WIDTH   (PID_WIDTH)
  ) u_sel_cur (
    .tmask_i     (tmask_q),
    .pid_i       (pid_q),
    .next_pid_o  (w_next_pid),
    .first_pid_o (w_unused_cur_first),
    .last_o      (w_last)
  );

  // First packet of the incoming warp, needed in the capture cycle.
  vx_dot8_dispatch_pkt_select #(
    .NUM_LANES   (NUM_LANES),
    .NUM_PACKETS (NUM_PACKETS),
    .PID_WIDTH   (PID_WIDTH)
  ) u_sel_in (
    .tmask_i     (dispatch_if.tmask),
    .pid_i       ('0),
    .next_pid_o  (w_unused_in_next),
    .first_pid_o (w_first_pid),
    .last_o      (w_unused_in_last)
  );
`else
  localparam logic [PID_WIDTH-1:0] LAST_PID = PID_WIDTH'(NUM_PACKETS - 1);

  assign w_first_pid = '0;
  assign w_next_pid  = pid_q + PID_WIDTH'(1);
  assign w_last      = (pid_q == LAST_PID);
`endif

  assign w_valid      = (state_q == SEND);
  assign w_exe_fire   = w_valid & execute_if.ready;
  // Accept a warp when idle, or while the current warp's eop is handed off.
  assign w_disp_ready = (state_q == IDLE) | (w_exe_fire & w_last);
  assign w_disp_fire  = dispatch_if.valid & w_disp_ready;

  // Next-state: capture, advance on handshake, chain or retire after eop.
  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    sop_d   = sop_q;
    case (state_q)
      IDLE: begin
        if (w_disp_fire) begin
          state_d = SEND;
          pid_d   = w_first_pid;
          sop_d   = 1'b1;
        end
      end
      SEND: begin
        if (w_exe_fire) begin
          if (w_last) begin
            if (dispatch_if.valid) begin
              pid_d = w_first_pid;
              sop_d = 1'b1;
            end else begin
              state_d = IDLE;
              pid_d   = '0;
              sop_d   = 1'b0;
            end
          end else begin
            pid_d = w_next_pid;
            sop_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pid_d   = '0;
        sop_d   = 1'b0;
      end
    endcase
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pid_q   <= '0;
      sop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      sop_q   <= sop_d;
    end
  end

  // Warp payload; contents are irrelevant until a capture, so no reset.
  always_ff @(posedge clk) begin
    if (w_disp_fire) begin
      uuid_q  <= dispatch_if.uuid;
      wid_q   <= dispatch_if.wid;
      tmask_q <= dispatch_if.tmask;
      pc_q    <= dispatch_if.PC;
      wb_q    <= dispatch_if.wb;
      rd_q    <= dispatch_if.rd;
      rs1_q   <= dispatch_if.rs1_data;
      rs2_q   <= dispatch_if.rs2_data;
    end
  end

  // Lane slice for the current pid, selected with constant part-selects.
  always_comb begin
    execute_if.tmask    = '0;
    execute_if.rs1_data = '0;
    execute_if.rs2_data = '0;
    for (int p = 0; p < NUM_PACKETS; p++) begin
      if (pid_q == PID_WIDTH'(p)) begin
        execute_if.tmask    = tmask_q[p*NUM_LANES +: NUM_LANES];
        execute_if.rs1_data = rs1_q[p*NUM_LANES +: NUM_LANES];
        execute_if.rs2_data = rs2_q[p*NUM_LANES +: NUM_LANES];
      end
    end
  end

  assign dispatch_if.ready   = w_disp_ready;
  assign execute_if.valid    = w_valid;
  assign execute_if.uuid     = uuid_q;
  assign execute_if.wid      = wid_q;
  assign execute_if.PC       = pc_q;
  assign execute_if.wb       = wb_q;
  assign execute_if.rd       = rd_q;
  assign execute_if.op_type  = '0;
  assign execute_if.op_args  = '0;
  assign execute_if.rs3_data = '0;
  assign execute_if.pid      = pid_q;
  assign execute_if.sop      = sop_q;
  assign execute_if.eop      = w_valid & w_last;

endmodule
`default_nettype wire

// File: tb/tb_vx_dot8_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vx_dot8_dispatch
//  Description : Scoreboard bench for vx_dot8_dispatch, one instance with
//                NUM_LANES=1 and one with NUM_LANES=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_dot8_dispatch;
  import vx_dot8_dispatch_pkg::*;

`ifdef DOT8_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [43:0]      uuid;
    logic [1:0]       wid;
    logic [3:0]       tmask;
    logic [31:0]      pc;
    logic             wb;
    logic [4:0]       rd;
    logic [3:0][31:0] rs1;
    logic [3:0][31:0] rs2;
  } warp_t;

  typedef struct packed {
    logic [43:0]      uuid;
    logic [1:0]       wid;
    logic [3:0]       tmask;
    logic [31:0]      pc;
    logic             wb;
    logic [4:0]       rd;
    logic [3:0][31:0] rs1;
    logic [3:0][31:0] rs2;
    logic [1:0]       pid;
    logic             sop;
    logic             eop;
  } pkt_t;

  logic clk = 1'b0;
  logic reset;
  bit   rand_mode = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  pkt_t q1[$];
  pkt_t q4[$];
  bit   held_v[2];
  pkt_t held_pkt[2];
  int   exp_next[2];
  pkt_t a1, a4;

  always #5 clk = ~clk;

  vx_dispatch_if di1();
  vx_dispatch_if di4();
  vx_execute_if #(.NUM_LANES(1), .PID_WIDTH(2)) ex1();
  vx_execute_if #(.NUM_LANES(4), .PID_WIDTH(1)) ex4();

  vx_dot8_dispatch #(.INSTANCE_ID("dut1"), .NUM_LANES(1)) u_dut1 (
    .clk(clk), .reset(reset), .dispatch_if(di1), .execute_if(ex1));
  vx_dot8_dispatch #(.INSTANCE_ID("dut4"), .NUM_LANES(4)) u_dut4 (
    .clk(clk), .reset(reset), .dispatch_if(di4), .execute_if(ex4));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: list the packets to issue, then frame first/last.
  task automatic push_warp(input int d, input warp_t w);
    int nl, np;
    int sel[$];
    logic [3:0] sl;
    pkt_t e;
    nl = (d == 0) ? 1 : 4;
    np = 4 / nl;
    for (int p = 0; p < np; p++) begin
      sl = '0;
      for (int l = 0; l < nl; l++) sl[l] = w.tmask[p*nl+l];
      if (!SKIP || sl != 4'd0) sel.push_back(p);
    end
    if (sel.size() == 0) sel.push_back(0);
    foreach (sel[k]) begin
      e = '0;
      e.uuid = w.uuid; e.wid = w.wid; e.pc = w.pc; e.wb = w.wb; e.rd = w.rd;
      e.pid = 2'(sel[k]);
      for (int l = 0; l < nl; l++) begin
        e.tmask[l] = w.tmask[sel[k]*nl+l];
        e.rs1[l]   = w.rs1[sel[k]*nl+l];
        e.rs2[l]   = w.rs2[sel[k]*nl+l];
      end
      e.sop = (k == 0);
      e.eop = (k == sel.size() - 1);
      if (d == 0) q1.push_back(e); else q4.push_back(e);
    end
  endtask

  // Monitor rules applied once per cycle to one DUT.
  task automatic mon_step(input int d, input logic v, input logic r,
                          input logic dv, input logic dr, input pkt_t act);
    pkt_t e;
    if (exp_next[d] == 1) check($sformatf("valid_after_capture_or_advance%0d", d), 64'(v), 64'd1);
    else if (exp_next[d] == 2) check($sformatf("idle_after_eop%0d", d), 64'(v), 64'd0);
    exp_next[d] = 0;
    if (held_v[d]) begin
      n_checks++;
      if (!v || act !== held_pkt[d]) begin
        n_errors++;
        $display("FAIL hold%0d: got v=%0b %h expected %h", d, v, act, held_pkt[d]);
      end
    end
    held_v[d] = 1'b0;
    if (v) check($sformatf("disp_ready_busy%0d", d), 64'(dr), 64'(r && act.eop));
    else   check($sformatf("disp_ready_idle%0d", d), 64'(dr), 64'd1);
    if (v && r) begin
      n_checks++;
      if ((d == 0 && q1.size() == 0) || (d == 1 && q4.size() == 0)) begin
        n_errors++;
        $display("FAIL pkt%0d: got unexpected %h expected none", d, act);
      end else begin
        e = (d == 0) ? q1.pop_front() : q4.pop_front();
        if (act !== e) begin
          n_errors++;
          $display("FAIL pkt%0d: got %h expected %h", d, act, e);
        end
      end
      exp_next[d] = act.eop ? ((dv && dr) ? 1 : 2) : 1;
    end else if (v) begin
      held_v[d]   = 1'b1;
      held_pkt[d] = act;
    end else if (dv && dr) begin
      exp_next[d] = 1;
    end
  endtask

  always @(negedge clk) begin
    a1 = '0;
    a1.uuid = ex1.uuid; a1.wid = ex1.wid; a1.pc = ex1.PC; a1.wb = ex1.wb; a1.rd = ex1.rd;
    a1.tmask = 4'(ex1.tmask); a1.rs1[0] = ex1.rs1_data[0]; a1.rs2[0] = ex1.rs2_data[0];
    a1.pid = ex1.pid; a1.sop = ex1.sop; a1.eop = ex1.eop;
    if (reset) mon_step(0, ex1.valid, ex1.ready, di1.valid, di1.ready, a1);
    else begin held_v[0] = 1'b0; exp_next[0] = 0; end
  end

  always @(negedge clk) begin
    a4 = '0;
    a4.uuid = ex4.uuid; a4.wid = ex4.wid; a4.pc = ex4.PC; a4.wb = ex4.wb; a4.rd = ex4.rd;
    a4.tmask = ex4.tmask;
    for (int l = 0; l < 4; l++) begin
      a4.rs1[l] = ex4.rs1_data[l];
      a4.rs2[l] = ex4.rs2_data[l];
    end
    a4.pid = 2'(ex4.pid); a4.sop = ex4.sop; a4.eop = ex4.eop;
    if (reset) mon_step(1, ex4.valid, ex4.ready, di4.valid, di4.ready, a4);
    else begin held_v[1] = 1'b0; exp_next[1] = 0; end
  end

  // Random execute-side backpressure during the random phase.
  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      ex1.ready = ($urandom_range(0, 3) != 0);
      ex4.ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive(input int d, input warp_t w, input logic v);
    if (d == 0) begin
      di1.valid = v; di1.uuid = w.uuid; di1.wid = w.wid; di1.tmask = w.tmask;
      di1.PC = w.pc; di1.wb = w.wb; di1.rd = w.rd;
      di1.rs1_data = w.rs1; di1.rs2_data = w.rs2;
    end else begin
      di4.valid = v; di4.uuid = w.uuid; di4.wid = w.wid; di4.tmask = w.tmask;
      di4.PC = w.pc; di4.wb = w.wb; di4.rd = w.rd;
      di4.rs1_data = w.rs1; di4.rs2_data = w.rs2;
    end
  endtask

  // Present a warp and hold it until accepted; returns #1 after the capture edge.
  task automatic send_warp(input int d, input warp_t w);
    bit fire;
    int guard;
    fire  = 1'b0;
    guard = 0;
    drive(d, w, 1'b1);
    while (!fire) begin
      @(negedge clk);
      fire = (d == 0) ? di1.ready : di4.ready;
      if (fire) push_warp(d, w);
      @(posedge clk); #1;
      guard++;
      if (!fire && guard > 200) begin
        n_checks++; n_errors++;
        $display("FAIL dispatch_timeout%0d: got no ready expected ready within 200 cycles", d);
        break;
      end
    end
    drive(d, w, 1'b0);
  endtask

  function automatic warp_t rand_warp(input logic [3:0] mask);
    warp_t w;
    w.uuid  = {12'($urandom), $urandom};
    w.wid   = 2'($urandom);
    w.tmask = mask;
    w.pc    = $urandom;
    w.wb    = 1'($urandom);
    w.rd    = 5'($urandom);
    for (int i = 0; i < 4; i++) begin
      w.rs1[i] = $urandom;
      w.rs2[i] = $urandom;
    end
    return w;
  endfunction

  initial begin
    warp_t w;
    int guard;
    reset = 1'b0;
    ex1.ready = 1'b0;
    ex4.ready = 1'b0;
    w = rand_warp(4'hF);
    drive(0, w, 1'b0);
    drive(1, w, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid1", 64'(ex1.valid), 64'd0);
    check("rst_pid1",   64'(ex1.pid),   64'd0);
    check("rst_sop1",   64'(ex1.sop),   64'd0);
    check("rst_eop1",   64'(ex1.eop),   64'd0);
    check("rst_valid4", 64'(ex4.valid), 64'd0);
    check("rst_ready1", 64'(di1.ready), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Full mask, no backpressure.
    ex1.ready = 1'b1;
    w = rand_warp(4'hF);
    for (int i = 0; i < 4; i++) begin
      w.rs1[i] = 32'h01020304;
      w.rs2[i] = 32'h01010101;
    end
    send_warp(0, w);
    repeat (6) @(posedge clk);
    #1;

    // Backpressure for 3 cycles while pid1 is presented.
    send_warp(0, rand_warp(4'hF));
    @(posedge clk); #1;
    ex1.ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_pid", 64'(ex1.pid), 64'd1);
      @(posedge clk); #1;
    end
    ex1.ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Back-to-back warps, then sparse masks.
    send_warp(0, rand_warp(4'hF));
    send_warp(0, rand_warp(4'hA));
    send_warp(0, rand_warp(4'b0100));
    send_warp(0, rand_warp(4'b0000));
    repeat (6) @(posedge clk);
    #1;

    // Four-lane instance: a warp is a single packet.
    ex4.ready = 1'b1;
    send_warp(1, rand_warp(4'hF));
    send_warp(1, rand_warp(4'h0));
    send_warp(1, rand_warp(4'h6));
    repeat (4) @(posedge clk);
    #1;

    // Reset after the pid1 handshake discards the rest of the warp.
    send_warp(0, rand_warp(4'hF));
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(ex1.valid), 64'd0);
    check("mid_rst_pid",   64'(ex1.pid),   64'd0);
    check("mid_rst_sop",   64'(ex1.sop),   64'd0);
    check("mid_rst_eop",   64'(ex1.eop),   64'd0);
    check("mid_rst_pending", 64'(q1.size()), SKIP ? 64'd2 : 64'd2);
    q1.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", 64'(ex1.valid), 64'd0);
      check("post_rst_ready", 64'(di1.ready), 64'd1);
    end
    @(posedge clk); #1;

    // Random warps with random backpressure on both instances.
    rand_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [3:0] m;
      m = 4'($urandom);
      if ($urandom_range(0, 5) == 0) m = 4'h0;
      send_warp($urandom_range(0, 1), rand_warp(m));
    end
    rand_mode = 1'b0;
    @(posedge clk); #2;
    ex1.ready = 1'b1;
    ex4.ready = 1'b1;
    guard = 0;
    while ((q1.size() != 0 || q4.size() != 0) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain1", 64'(q1.size()), 64'd0);
    check("drain4", 64'(q4.size()), 64'd0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vx_dot8_dispatch.md
VX_DOT8_DISPATCH -- requirements
Module: VX_dot8_dispatch

Interface
REQ-001 SHALL have parameter INSTANCE_ID, default "", trace instance name.
REQ-002 SHALL have parameter NUM_LANES, default 1, lanes per issued packet; SHALL divide `NUM_THREADS.
REQ-003 SHALL have localparam NUM_PACKETS = `NUM_THREADS / NUM_LANES and PID_WIDTH = `UP(`CLOG2(NUM_PACKETS)).
REQ-004 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- dispatch_if  VX_dispatch_if.slave  full-warp operands: uuid, wid, tmask[`NUM_THREADS], PC, wb, rd, rs1_data/rs2_data[`NUM_THREADS][`XLEN].
- execute_if  VX_execute_if.master  NUM_LANES-wide packets to the dot8 unit: uuid, wid, tmask, PC, wb, rd, rs1/rs2_data, pid, sop, eop; op_type/op_args/rs3_data driven 0.

Function
REQ-005 SHALL use two states: IDLE, SEND.
REQ-006 In IDLE, dispatch_if.ready SHALL be 1; a handshake SHALL capture the full warp into an internal register and enter SEND.
REQ-007 execute_if.valid SHALL be registered: first packet valid the cycle after capture, 1-cycle latency.
REQ-008 Packet p SHALL carry lanes [p*NUM_LANES +: NUM_LANES] of tmask, rs1_data and rs2_data, with pid = p.
REQ-009 sop SHALL be 1 only on the first packet emitted for a warp; eop SHALL be 1 only on the last.
REQ-010 Output fields SHALL hold stable while execute_if.valid=1 and execute_if.ready=0.
REQ-011 On an execute_if handshake with eop=0, the unit SHALL advance to the next emitted pid the following cycle.
REQ-012 On an execute_if handshake with eop=1:
- dispatch_if.ready SHALL be 1 in that same cycle.
- A simultaneous dispatch_if.valid SHALL be captured, with no idle bubble between warps.
- Otherwise the unit SHALL return to IDLE with execute_if.valid=0.
REQ-013 When NUM_PACKETS=1, every packet SHALL have sop=eop=1 and pid=0.
REQ-014 dispatch_if.ready SHALL be 0 in SEND except in the eop-handshake cycle.

Reset
REQ-015 While reset=0:
- state=IDLE, execute_if.valid=0, pid=0, sop=0, eop=0.
- Captured payload SHALL be don't-care.
REQ-016 Reset asserted mid-warp SHALL discard the remaining packets; after release no partial packet SHALL be emitted.

Configuration
REQ-017 With DOT8_SKIP_EMPTY_EN defined:
- Packets whose tmask slice is all-zero SHALL NOT be emitted.
- sop/eop SHALL mark the first and last non-empty packets.
- If the whole tmask is zero, exactly one packet (pid 0, sop=eop=1, tmask 0) SHALL be emitted.
REQ-018 Without DOT8_SKIP_EMPTY_EN, all NUM_PACKETS packets SHALL be emitted in pid order regardless of tmask.

Structure
REQ-019 PID width and packet-count helpers SHALL live in VX_gpu_pkg; state encoding SHALL be local.
REQ-020 Non-empty slice search SHALL be one sub-module, VX_dot8_pkt_select:
- Inputs: tmask, current pid.
- Outputs: next non-empty pid, first non-empty pid, last-flag.
- Used only when DOT8_SKIP_EMPTY_EN is defined.

Verification (`NUM_THREADS=4, NUM_LANES=1, XLEN=32 unless noted)
REQ-021 Full mask: tmask=4'b1111, rs1[i]=0x01020304, rs2[i]=0x01010101, execute_if.ready=1 -> 4 packets on consecutive cycles, pid 0,1,2,3, sop on pid0, eop on pid3, first valid 1 cycle after capture.
REQ-022 Backpressure: execute_if.ready=0 for 3 cycles during pid1 -> pid1 payload held stable, no packet lost or duplicated, dispatch_if.ready=0 throughout.
REQ-023 Back-to-back: second warp valid during the eop handshake of the first -> second warp's pid0/sop appears the next cycle, no bubble.
REQ-024 Skip, DOT8_SKIP_EMPTY_EN defined: tmask=4'b0100 -> exactly one packet, pid=2, sop=eop=1. tmask=0 -> one packet, pid0, sop=eop=1.
REQ-025 Reset: reset=0 asserted after the pid1 handshake -> valid drops asynchronously. After release, idle with dispatch_if.ready=1 and no pid2 emitted.
REQ-026 NUM_LANES=4: one warp -> single packet, pid=0, sop=eop=1, all 4 lanes forwarded.
